// File: rtl/mm_arbiter.sv
// mm_arbiter: round-robin arbiter sharing one mainmemory line port
// between two L1 cache controllers, with a read-response watchdog.
module mm_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  p0_a,
    input  logic         p0_read,
    input  logic         p0_write,
    input  logic [255:0] p0_wd,
    output logic         p0_ready,
    output logic [255:0] p0_rd,
    output logic         p0_rd_valid,
    input  logic [31:0]  p1_a,
    input  logic         p1_read,
    input  logic         p1_write,
    input  logic [255:0] p1_wd,
    output logic         p1_ready,
    output logic [255:0] p1_rd,
    output logic         p1_rd_valid,
    output logic [26:0]  mm_a,
    output logic [255:0] mm_wd,
    output logic         mm_read,
    output logic         mm_write,
    input  logic [255:0] mm_rd,
    input  logic         mm_valid,
    input  logic         mm_ready,
    output logic         err
);
    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, WR_WAIT} state_t;

    state_t       state;
    state_t       state_nx;
    logic         op_rd;
    logic         gnt;
    logic         last_grant;
    logic         drop;
    logic [26:0]  cmd_a;
    logic [255:0] cmd_wd;
    logic [7:0]   wdog;

    logic         req0;
    logic         req1;
    logic         win1;
    logic         grant;
    logic         sel_rd;
    logic         sel_wr;
    logic [26:0]  sel_a;
    logic [255:0] sel_wd;
    logic         hit;
    logic         unused_lsb;

    assign req0   = p0_read | p0_write;
    assign req1   = p1_read | p1_write;
    assign win1   = req1 & (~req0 | ~last_grant);
    assign sel_rd = win1 ? p1_read : p0_read;
    assign sel_wr = win1 ? p1_write : p0_write;
    assign sel_a  = win1 ? p1_a[31:5] : p0_a[31:5];
    assign sel_wd = win1 ? p1_wd : p0_wd;
    assign hit    = (wdog == 8'(TIMEOUT));

    assign unused_lsb = ^{p0_a[4:0], p1_a[4:0]};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        grant       = 1'b0;
        p0_ready    = 1'b0;
        p1_ready    = 1'b0;
        p0_rd_valid = 1'b0;
        p1_rd_valid = 1'b0;
        p0_rd       = mm_rd;
        p1_rd       = mm_rd;
        mm_read     = 1'b0;
        mm_write    = 1'b0;
        mm_a        = '0;
        mm_wd       = '0;
        unique case (state)
            IDLE: begin
                if ((req0 | req1) && mm_ready) begin
                    grant    = 1'b1;
                    p0_ready = ~win1;
                    p1_ready = win1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                mm_read  = op_rd;
                mm_write = ~op_rd;
                mm_a     = cmd_a;
                mm_wd    = cmd_wd;
                state_nx = op_rd ? RD_WAIT : WR_WAIT;
            end
            RD_WAIT: begin
                if (mm_valid || hit) begin
                    p0_rd_valid = ~gnt;
                    p1_rd_valid = gnt;
                    state_nx    = IDLE;
                    // A real response beats a same-cycle watchdog expiry
                    if (!mm_valid) begin
                        p0_rd = '0;
                        p1_rd = '0;
                    end
                end
            end
            WR_WAIT: begin
                if (mm_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_rd      <= 1'b0;
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            cmd_a      <= '0;
            cmd_wd     <= '0;
            wdog       <= '0;
            err        <= 1'b0;
            // Remember an abandoned read so its late response is swallowed
            if (state == RD_WAIT || (state == ISSUE && op_rd))
                drop <= 1'b1;
        end else begin
            if (grant) begin
                op_rd      <= sel_rd;
                gnt        <= win1;
                last_grant <= win1;
                cmd_a      <= sel_a;
                cmd_wd     <= sel_wd;
                drop       <= 1'b0;
                if (sel_rd && sel_wr) err <= 1'b1;
            end
            if (state == ISSUE)
                wdog <= '0;
            else if (state == RD_WAIT)
                wdog <= wdog + 8'd1;
            if (state == RD_WAIT && hit && !mm_valid)
                err <= 1'b1;
            if (mm_valid && state != RD_WAIT) begin
                if (!drop) err <= 1'b1;
                drop <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mm_arbiter.sv
// tb_mm_arbiter: scoreboard bench for mm_arbiter with a small
// mainmemory model (READ_LAT 4, WRITE_TPUT 4) and two port agents.
module tb_mm_arbiter;
    localparam int TO = 8;
    localparam logic [255:0] FILLER = {8{32'hDEAD_BEEF}};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  p0_a, p1_a;
    logic         p0_read, p0_write, p1_read, p1_write;
    logic [255:0] p0_wd, p1_wd;
    logic         p0_ready, p1_ready;
    logic [255:0] p0_rd, p1_rd;
    logic         p0_rd_valid, p1_rd_valid;
    logic [26:0]  mm_a;
    logic [255:0] mm_wd;
    logic         mm_read, mm_write;
    logic [255:0] mm_rd = FILLER;
    logic         mm_valid = 1'b0;
    logic         mm_ready = 1'b1;
    logic         err;

    mm_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .p0_a(p0_a), .p0_read(p0_read), .p0_write(p0_write),
        .p0_wd(p0_wd), .p0_ready(p0_ready), .p0_rd(p0_rd),
        .p0_rd_valid(p0_rd_valid),
        .p1_a(p1_a), .p1_read(p1_read), .p1_write(p1_write),
        .p1_wd(p1_wd), .p1_ready(p1_ready), .p1_rd(p1_rd),
        .p1_rd_valid(p1_rd_valid),
        .mm_a(mm_a), .mm_wd(mm_wd), .mm_read(mm_read),
        .mm_write(mm_write), .mm_rd(mm_rd), .mm_valid(mm_valid),
        .mm_ready(mm_ready), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rd; bit wr; logic [31:0] a; logic [255:0] wd;
    } req_t;
    typedef struct {
        int port; bit rd; logic [26:0] a; logic [255:0] wd;
    } cmd_t;
    typedef struct {
        int port; logic [255:0] d; int cyc;
    } rsp_t;

    req_t q0[$], q1[$];
    int   exp_gnt[$];
    cmd_t cmdq[$];
    rsp_t rspq[$];
    req_t held0, held1, r;
    cmd_t c;
    rsp_t s;
    int   checks = 0, failures = 0, cyc = 0;
    int   gnt_cyc = 0, p = 0;
    bit   acc0 = 0, acc1 = 0, mute = 0;

    int          mem_cnt = 0;
    bit          mem_rd = 0;
    logic [26:0] mem_a = '0;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] line(input logic [26:0] a);
        return {8{a, 5'h15}};
    endfunction

    function automatic logic [255:0] rnd256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        mm_valid <= 1'b0;
        mm_rd    <= FILLER;
        if (mem_cnt > 0) begin
            mem_cnt <= mem_cnt - 1;
            if (mem_cnt == 1) begin
                mm_ready <= 1'b1;
                if (mem_rd && !mute) begin
                    mm_valid <= 1'b1;
                    mm_rd    <= line(mem_a);
                end
            end
        end else if (mm_read || mm_write) begin
            mm_ready <= 1'b0;
            mem_cnt  <= 3;
            mem_rd   <= mm_read;
            mem_a    <= mm_a;
        end
    end

    initial begin
        p0_read = 0; p0_write = 0; p0_a = '0; p0_wd = '0;
        forever begin
            @(posedge clk); #1;
            if (acc0) begin p0_read = 0; p0_write = 0; end
            if (!p0_read && !p0_write && q0.size() > 0) begin
                held0 = q0.pop_front();
                p0_read = held0.rd; p0_write = held0.wr;
                p0_a = held0.a; p0_wd = held0.wd;
            end
        end
    end

    initial begin
        p1_read = 0; p1_write = 0; p1_a = '0; p1_wd = '0;
        forever begin
            @(posedge clk); #1;
            if (acc1) begin p1_read = 0; p1_write = 0; end
            if (!p1_read && !p1_write && q1.size() > 0) begin
                held1 = q1.pop_front();
                p1_read = held1.rd; p1_write = held1.wr;
                p1_a = held1.a; p1_wd = held1.wd;
            end
        end
    end

    always @(negedge clk) begin
        acc0 = p0_ready & ~reset;
        acc1 = p1_ready & ~reset;
        if (!reset) begin
            if (p0_ready || p1_ready) begin
                chk("rdy_both", p0_ready & p1_ready, 0);
                p = p1_ready ? 1 : 0;
                if (exp_gnt.size() == 0) chk("gnt_unexp", p, 2);
                else chk("gnt_port", p, exp_gnt.pop_front());
                r = p ? held1 : held0;
                cmdq.push_back('{p, r.rd, r.a[31:5], r.wd});
                gnt_cyc = cyc;
            end
            if (mm_read || mm_write) begin
                chk("cmd_busy", mem_cnt != 0, 0);
                if (cmdq.size() == 0) begin
                    chk("cmd_unexp", {mm_read, mm_write}, 0);
                end else begin
                    c = cmdq.pop_front();
                    chk("cmd_cyc", cyc, gnt_cyc + 1);
                    chk("cmd_rd", mm_read, c.rd);
                    chk("cmd_wr", mm_write, !c.rd);
                    chk("mm_a", mm_a, c.a);
                    if (!c.rd) chk("mm_wd", mm_wd, c.wd);
                    if (c.rd)
                        rspq.push_back('{c.port,
                            mute ? 256'b0 : line(c.a),
                            mute ? gnt_cyc + 2 + TO : gnt_cyc + 5});
                end
            end
            if (p0_rd_valid || p1_rd_valid) begin
                chk("rv_both", p0_rd_valid & p1_rd_valid, 0);
                if (rspq.size() == 0) begin
                    chk("rv_unexp", {p0_rd_valid, p1_rd_valid}, 0);
                end else begin
                    s = rspq.pop_front();
                    chk("rv_port", p1_rd_valid, s.port);
                    chk("rv_cyc", cyc, s.cyc);
                    chk("rv_data", p1_rd_valid ? p1_rd : p0_rd, s.d);
                end
            end
        end
    end

    task automatic push(input int port, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [255:0] wd);
        req_t q;
        q.rd = rd; q.wr = wr; q.a = a; q.wd = wd;
        if (port == 0) q0.push_back(q);
        else q1.push_back(q);
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        bit busy = 1;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
            busy = q0.size() > 0 || q1.size() > 0 || exp_gnt.size() > 0 ||
                   cmdq.size() > 0 || rspq.size() > 0 || mem_cnt != 0 ||
                   p0_read || p0_write || p1_read || p1_write;
        end
        chk("wait_budget", busy, 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_reset_outs();
        chk("rst_mm_read", mm_read, 0);
        chk("rst_mm_write", mm_write, 0);
        chk("rst_mm_a", mm_a, 0);
        chk("rst_mm_wd", mm_wd, 0);
        chk("rst_rv", {p0_rd_valid, p1_rd_valid}, 0);
        chk("rst_err", err, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        repeat (2) @(negedge clk);
        chk_reset_outs();
        chk("rst_ready", {p0_ready, p1_ready}, 0);
        reset = 0;
    endtask

    initial begin
        int n;
        do_reset();

        // contention straight after reset: port 0 first, then port 1 write
        push(0, 1, 0, 32'h0000_1000, '0);
        push(1, 0, 1, 32'h0000_2040, rnd256());
        exp_gnt.push_back(0); exp_gnt.push_back(1);
        wait_quiet(100);

        // fairness: both ports hold reads continuously
        for (int i = 0; i < 3; i++) begin
            push(0, 1, 0, 32'h0001_0000 + 32'(i * 32), '0);
            push(1, 1, 0, 32'h0002_0000 + 32'(i * 32), '0);
            exp_gnt.push_back(0); exp_gnt.push_back(1);
        end
        wait_quiet(200);

        // single read at 0x120 -> line address 9
        push(0, 1, 0, 32'h0000_0120, '0);
        exp_gnt.push_back(0);
        wait_quiet(100);
        chk("single_line9", line(27'h9), {8{27'h9, 5'h15}});

        // write throttle: read must wait for mm_ready after the write
        push(1, 0, 1, 32'h0000_3000, rnd256());
        exp_gnt.push_back(1);
        @(negedge clk);
        push(0, 1, 0, 32'h0000_3020, '0);
        exp_gnt.push_back(0);
        wait_quiet(100);
        chk("throttle_err", err, 0);

        // watchdog expiry, then a normal read
        mute = 1;
        push(1, 1, 0, 32'h0000_4000, '0);
        exp_gnt.push_back(1);
        wait_quiet(100);
        mute = 0;
        chk("timeout_err", err, 1);
        push(0, 1, 0, 32'h0000_4040, '0);
        exp_gnt.push_back(0);
        wait_quiet(100);
        chk("post_to_err", err, 1);

        // reset in the middle of a read
        do_reset();
        push(0, 1, 0, 32'h0000_5000, '0);
        exp_gnt.push_back(0);
        n = 0;
        while (rspq.size() == 0 && n < 50) begin @(negedge clk); n++; end
        chk("midrd_issue", rspq.size(), 1);
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        rspq.delete();
        cmdq.delete();
        @(negedge clk);
        chk_reset_outs();
        repeat (6) @(negedge clk);
        chk("midrd_err", err, 0);
        push(0, 1, 0, 32'h0000_6000, '0);
        push(1, 1, 0, 32'h0000_6020, '0);
        exp_gnt.push_back(0); exp_gnt.push_back(1);
        wait_quiet(100);
        chk("midrd_err2", err, 0);

        // same port with read and write: read performed, err set
        push(1, 1, 1, 32'h0000_7000, rnd256());
        exp_gnt.push_back(1);
        wait_quiet(100);
        chk("dual_err", err, 1);

        chk("left_over", exp_gnt.size() + cmdq.size() + rspq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "global timeout");
    end
endmodule
